// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: FIFO-buffered opcode/operand issue controller for the accumulator ALU
module alu_op_sequencer #(
  parameter int DEPTH = 8,
  parameter bit HALT_ON_ERR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_opcode,
  input  logic [15:0] in_operand,
  input  logic        run_en,
  input  logic        flush,
  input  logic        clear_err,
  output logic [3:0]  alu_opcode,
  output logic [15:0] alu_a,
  input  logic [15:0] alu_c,
  input  logic        alu_e,
  output logic        res_valid,
  output logic [15:0] res_data,
  output logic        res_err,
  output logic        res_ill,
  output logic        err_flag,
  output logic        busy,
  output logic [15:0] issue_cnt
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {INIT, RUN, HALT} state_t;
  state_t state_q, state_d;
  logic [19:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic res_valid_q, res_valid_d, res_err_q, res_err_d, res_ill_q, res_ill_d, err_q, err_d;
  logic [15:0] res_data_q, res_data_d, issue_cnt_q, issue_cnt_d;
  logic full, empty, push, issue, ill, ovf;
  logic [3:0] head_op;
  always_comb begin
    full = cnt_q == (AW+1)'(DEPTH);
    empty = cnt_q == '0;
    in_ready = !full && !flush && !rst;
    push = in_valid && in_ready;
    issue = state_q == RUN && run_en && !empty;
    head_op = mem_q[rd_q][19:16];
    ill = head_op inside {4'b0010, 4'b0011, 4'b0110, 4'b0111, 4'b1110, 4'b1111};
    ovf = issue && head_op == 4'b0100 && alu_e;
    alu_opcode = state_q == INIT ? 4'b0001 : (issue && !ill) ? head_op : 4'b0000;
    alu_a = issue ? mem_q[rd_q][15:0] : 16'h0;
    wr_d = wr_q + AW'(push);
    rd_d = flush ? wr_q : rd_q + AW'(issue);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(issue);
    state_d = state_q == INIT ? RUN :
              state_q == HALT ? (clear_err ? RUN : HALT) :
              (ovf && HALT_ON_ERR) ? HALT : RUN;
    err_d = ovf ? 1'b1 : clear_err ? 1'b0 : err_q;
    res_valid_d = issue;
    res_data_d = issue ? alu_c : res_data_q;
    res_err_d = issue ? alu_e && !ill : res_err_q;
    res_ill_d = issue ? ill : res_ill_q;
    issue_cnt_d = issue_cnt_q + 16'(issue);
    busy = !empty || state_q != RUN;
  end
  // payload storage carries no reset; occupancy is tracked by cnt_q
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= {in_opcode, in_operand};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= INIT;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      res_valid_q <= 1'b0;
      res_data_q <= 16'h0;
      res_err_q <= 1'b0;
      res_ill_q <= 1'b0;
      err_q <= 1'b0;
      issue_cnt_q <= 16'h0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      res_valid_q <= res_valid_d;
      res_data_q <= res_data_d;
      res_err_q <= res_err_d;
      res_ill_q <= res_ill_d;
      err_q <= err_d;
      issue_cnt_q <= issue_cnt_d;
    end
  assign res_valid = res_valid_q;
  assign res_data = res_data_q;
  assign res_err = res_err_q;
  assign res_ill = res_ill_q;
  assign err_flag = err_q;
  assign issue_cnt = issue_cnt_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed stimulus with a result scoreboard against an accumulator ALU model
module tb_alu_op_sequencer;
  logic clk = 0, rst = 1, in_valid = 0, run_en = 0, flush = 0, clear_err = 0;
  logic [3:0] in_opcode = 0;
  logic [15:0] in_operand = 0;
  logic in_ready, alu_e, res_valid, res_err, res_ill, err_flag, busy;
  logic [3:0] alu_opcode;
  logic [15:0] alu_a, alu_c, res_data, issue_cnt;
  logic [15:0] acc = 0;
  typedef struct packed {logic [15:0] d; logic e; logic i;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DEPTH(8), .HALT_ON_ERR(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_operand(in_operand), .run_en(run_en),
    .flush(flush), .clear_err(clear_err), .alu_opcode(alu_opcode),
    .alu_a(alu_a), .alu_c(alu_c), .alu_e(alu_e), .res_valid(res_valid),
    .res_data(res_data), .res_err(res_err), .res_ill(res_ill),
    .err_flag(err_flag), .busy(busy), .issue_cnt(issue_cnt)
  );

  // accumulator ALU: 0000 NOP, 0001 clear, 0100 ADD (carry -> e), 0101 SUB (borrow -> e)
  always_comb begin
    alu_c = acc;
    alu_e = 1'b0;
    case (alu_opcode)
      4'b0001: alu_c = 16'h0;
      4'b0100: {alu_e, alu_c} = {1'b0, acc} + {1'b0, alu_a};
      4'b0101: begin alu_c = acc - alu_a; alu_e = acc < alu_a; end
      default: ;
    endcase
  end
  always @(posedge clk) acc <= alu_c;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (!rst && res_valid) begin
      exp_t x;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got data=%0d err=%0b ill=%0b expected none", res_data, res_err, res_ill);
      end else begin
        x = sb.pop_front();
        check("result{data,err,ill}", {res_data, res_err, res_ill}, x);
      end
    end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic expect_res(input logic [15:0] d, input logic e, input logic i);
    sb.push_back('{d, e, i});
  endtask

  task automatic push(input logic [3:0] op, input logic [15:0] a);
    in_valid = 1; in_opcode = op; in_operand = a;
    step();
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin step(); n++; end
    step();
    check("drain_left", sb.size(), 0);
  endtask

  initial begin
    step(2);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_issue_cnt", issue_cnt, 0);
    check("rst_err_flag", err_flag, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 1);
    rst = 0;
    #1;
    check("init_opcode", alu_opcode, 4'b0001);
    check("init_a", alu_a, 0);
    check("init_in_ready", in_ready, 1);
    step();
    check("run_opcode", alu_opcode, 4'b0000);
    check("run_busy", busy, 0);
    check("run_issue_cnt", issue_cnt, 0);
    // overflow halts with the third ADD still queued
    run_en = 1;
    expect_res(16'd35000, 0, 0); push(4'b0100, 16'd35000);
    expect_res(16'd4464, 1, 0);  push(4'b0100, 16'd35000);
    push(4'b0100, 16'd1);
    step(3);
    check("halt_err_flag", err_flag, 1);
    check("halt_busy", busy, 1);
    check("halt_issue_cnt", issue_cnt, 2);
    check("halt_opcode", alu_opcode, 4'b0000);
    expect_res(16'd4465, 0, 0);
    clear_err = 1; step(); clear_err = 0;
    check("clear_err_flag", err_flag, 0);
    drain();
    check("resume_issue_cnt", issue_cnt, 3);
    expect_res(16'd0, 0, 0); push(4'b0001, 16'd0);
    expect_res(16'd4, 0, 0); push(4'b0100, 16'd4);
    expect_res(16'd1, 0, 0); push(4'b0101, 16'd3);
    drain();
    check("addsub_issue_cnt", issue_cnt, 6);
    // fill while paused, then burst out
    run_en = 0;
    for (int i = 0; i < 8; i++) begin expect_res(16'(2 + i), 0, 0); push(4'b0100, 16'd1); end
    check("full_in_ready", in_ready, 0);
    check("full_busy", busy, 1);
    in_valid = 1; in_opcode = 4'b0100; in_operand = 16'd100;
    step();
    in_valid = 0;
    run_en = 1;
    for (int i = 0; i < 8; i++) begin step(); check("burst_res_valid", res_valid, 1); end
    step();
    check("burst_end_res_valid", res_valid, 0);
    check("burst_end_busy", busy, 0);
    check("burst_issue_cnt", issue_cnt, 14);
    expect_res(16'd7, 0, 0); push(4'b0101, 16'd2);
    drain();
    run_en = 0;
    expect_res(16'd7, 0, 1); push(4'b0110, 16'd5);
    run_en = 1;
    #1;
    check("ill_opcode", alu_opcode, 4'b0000);
    drain();
    check("ill_issue_cnt", issue_cnt, 16);
    // flush discards queued entries and blocks a same-cycle push
    run_en = 0;
    repeat (3) push(4'b0100, 16'd9);
    check("prefl_busy", busy, 1);
    flush = 1; in_valid = 1; in_opcode = 4'b0100; in_operand = 16'd9;
    #1;
    check("flush_in_ready", in_ready, 0);
    step();
    flush = 0; in_valid = 0;
    check("flush_busy", busy, 0);
    run_en = 1;
    step(3);
    check("flush_issue_cnt", issue_cnt, 16);
    // reset while the second of two entries is issuing
    run_en = 0;
    expect_res(16'd8, 0, 0); push(4'b0100, 16'd1);
    push(4'b0100, 16'd1);
    run_en = 1;
    step();
    @(negedge clk); #1;
    rst = 1;
    #1;
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_res_data", res_data, 0);
    check("mid_rst_res_err", res_err, 0);
    check("mid_rst_res_ill", res_ill, 0);
    check("mid_rst_issue_cnt", issue_cnt, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_opcode", alu_opcode, 4'b0001);
    check("mid_rst_drained", sb.size(), 0);
    step();
    rst = 0;
    #1;
    check("reinit_opcode", alu_opcode, 4'b0001);
    check("reinit_busy", busy, 1);
    step();
    check("rerun_opcode", alu_opcode, 4'b0000);
    check("rerun_busy", busy, 0);
    expect_res(16'd5, 0, 0); push(4'b0100, 16'd5);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
